i2c_cmd_arbiter: RTL and testbench

Shares the single I2C master logic core between NUM_REQ independent requesters, for example the power-up config sequencer and a host or debug port. The block runs round-robin arbitration and latches the winner's command. It drives the core's mode, device, register and data inputs, detects transaction completion, and returns read data and ack status to the winner. It replaces the ad-hoc state-counter control that sat in front of the core.

---
 rtl/i2c_pkg.sv | 44 ++++
 rtl/i2c_rr_arb.sv | 36 +++
 rtl/i2c_cmd_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants, state encoding and command record for the I2C command arbiter.
// Mode codes match the I2C master core's mode input; ack indices select bits of its ack vector.
package i2c_pkg;

  localparam logic [7:0] I2C_WAIT         = 8'h00;
  localparam logic [7:0] I2C_SINGLE_WRITE = 8'h01;
  localparam logic [7:0] I2C_CONT_WRITE   = 8'h02;
  localparam logic [7:0] I2C_WRITE_DIRECT = 8'h03;
  localparam logic [7:0] I2C_SINGLE_READ  = 8'h04;
  localparam logic [7:0] I2C_CONT_READ    = 8'h05;
  localparam logic [7:0] I2C_READ_DIRECT  = 8'h06;

  localparam int ACK_NACK_BIT   = 1;
  localparam int ACK_DONE_W_BIT = 2;
  localparam int ACK_DONE_R_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] mode;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
  } cmd_t;

  // Continuous modes are deliberately excluded: the arbiter only issues single-byte commands.
  function automatic logic mode_legal(input logic [7:0] mode);
    case (mode)
      I2C_SINGLE_WRITE, I2C_WRITE_DIRECT,
      I2C_SINGLE_READ,  I2C_READ_DIRECT:  mode_legal = 1'b1;
      default:                            mode_legal = 1'b0;
    endcase
  endfunction

  function automatic logic mode_is_read(input logic [7:0] mode);
    mode_is_read = (mode == I2C_SINGLE_READ) || (mode == I2C_READ_DIRECT);
  endfunction

endpackage

// File: rtl/i2c_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr_i wins.
// Zero latency; grants nothing while en_i is low.
module i2c_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]    gnt_idx_o
);

  logic            found;
  int              cand;
  logic [IDXW-1:0] cand_idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      cand_idx = IDXW'(cand);
      if (en_i && !found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin front end sharing one I2C master core; accept->m_config 1 cycle, raw ack flag->req_done 3 cycles.
// Requesters hold req_valid until req_accept; optional BUSY watchdog enabled by `define I2C_TIMEOUT_EN.
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned GAP_CYC     = 16,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_200_000
) (
  input  logic                 clk_12m,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_mode,
  input  logic [7*NUM_REQ-1:0] req_dev_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]   req_accept,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 req_error,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic [7:0]           m_config,
  output logic [6:0]           m_dev_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_wr_data,
  input  logic [7:0]           m_ack,
  input  logic [7:0]           m_rd_data
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned GW   = $clog2(GAP_CYC + 1);

  state_e               state_q, state_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [IDXW-1:0]      win_q, win_d;
  cmd_t                 cmd_q, cmd_d, sel_cmd;
  logic [GW-1:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0]   req_accept_q, req_accept_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 req_error_q, req_error_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 busy_q, busy_d;
  logic [7:0]           m_config_q, m_config_d;
  logic [6:0]           m_dev_q, m_dev_d;
  logic [7:0]           m_reg_q, m_reg_d;
  logic [7:0]           m_wr_q, m_wr_d;

  logic [2:0]           ack_sel, ack_s1_q, ack_s2_q;
  logic                 done_prev_q, done_lvl, done_pulse, nack;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDXW-1:0]      gnt_idx;

`ifdef I2C_TIMEOUT_EN
  logic [23:0]          to_cnt_q, to_cnt_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  logic unused_ack;
  assign unused_ack = ^{m_ack[7:6], m_ack[4:3], m_ack[0]};

  // Each ack bit is synchronized on its own so the OR is taken on clean, clock-aligned levels.
  assign ack_sel    = {m_ack[ACK_DONE_R_BIT], m_ack[ACK_DONE_W_BIT], m_ack[ACK_NACK_BIT]};
  assign done_lvl   = ack_s2_q[2] | ack_s2_q[1];
  assign done_pulse = done_lvl & ~done_prev_q;
  assign nack       = ack_s2_q[0];

  i2c_rr_arb #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (state_q == ST_IDLE),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        sel_cmd.mode     = req_mode[8*i +: 8];
        sel_cmd.dev_addr = req_dev_addr[7*i +: 7];
        sel_cmd.reg_addr = req_reg_addr[8*i +: 8];
        sel_cmd.wr_data  = req_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    cmd_d        = cmd_q;
    gap_d        = gap_q;
    req_accept_d = '0;
    req_done_d   = '0;
    req_error_d  = 1'b0;
    rd_data_d    = '0;
    busy_d       = busy_q;
    m_config_d   = m_config_q;
    m_dev_d      = m_dev_q;
    m_reg_d      = m_reg_q;
    m_wr_d       = m_wr_q;
`ifdef I2C_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          req_accept_d = gnt;
          win_d        = gnt_idx;
          cmd_d        = sel_cmd;
          ptr_d        = (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (mode_legal(cmd_q.mode)) begin
          m_config_d = cmd_q.mode;
          m_dev_d    = cmd_q.dev_addr;
          m_reg_d    = cmd_q.reg_addr;
          m_wr_d     = cmd_q.wr_data;
          busy_d     = 1'b1;
          state_d    = ST_BUSY;
`ifdef I2C_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else begin
          // Illegal mode never reaches the core: report failure straight away.
          req_done_d[win_q] = 1'b1;
          req_error_d       = 1'b1;
          gap_d             = '0;
          state_d           = ST_GAP;
        end
      end
      ST_BUSY: begin
        if (done_pulse) begin
          req_done_d[win_q] = 1'b1;
          req_error_d       = nack;
          rd_data_d         = mode_is_read(cmd_q.mode) ? m_rd_data : 8'h00;
          m_config_d        = I2C_WAIT;
          gap_d             = '0;
          state_d           = ST_GAP;
        end
`ifdef I2C_TIMEOUT_EN
        else if (to_cnt_q == 24'(TIMEOUT_CYC - 24'd1)) begin
          req_done_d[win_q] = 1'b1;
          req_error_d       = 1'b1;
          m_config_d        = I2C_WAIT;
          gap_d             = '0;
          state_d           = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
`endif
      end
      ST_GAP: begin
        m_config_d = I2C_WAIT;
        if (gap_q == GW'(GAP_CYC - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      cmd_q        <= '0;
      gap_q        <= '0;
      req_accept_q <= '0;
      req_done_q   <= '0;
      req_error_q  <= 1'b0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      m_config_q   <= I2C_WAIT;
      m_dev_q      <= '0;
      m_reg_q      <= '0;
      m_wr_q       <= '0;
      ack_s1_q     <= '0;
      ack_s2_q     <= '0;
      done_prev_q  <= 1'b0;
`ifdef I2C_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      cmd_q        <= cmd_d;
      gap_q        <= gap_d;
      req_accept_q <= req_accept_d;
      req_done_q   <= req_done_d;
      req_error_q  <= req_error_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      m_config_q   <= m_config_d;
      m_dev_q      <= m_dev_d;
      m_reg_q      <= m_reg_d;
      m_wr_q       <= m_wr_d;
      ack_s1_q     <= ack_sel;
      ack_s2_q     <= ack_s1_q;
      done_prev_q  <= done_lvl;
`ifdef I2C_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign req_accept = req_accept_q;
  assign req_done   = req_done_q;
  assign req_error  = req_error_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign m_config   = m_config_q;
  assign m_dev_addr = m_dev_q;
  assign m_reg_addr = m_reg_q;
  assign m_wr_data  = m_wr_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: a behavioural core model raises ack bits, outputs sampled on negedge.
// Timeout case is compiled in only when I2C_TIMEOUT_EN is defined.
module tb_i2c_cmd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int GAP_CYC = 16;

  logic                 clk_12m = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_mode;
  logic [7*NUM_REQ-1:0] req_dev_addr;
  logic [8*NUM_REQ-1:0] req_reg_addr;
  logic [8*NUM_REQ-1:0] req_wr_data;
  logic [NUM_REQ-1:0]   req_accept;
  logic [NUM_REQ-1:0]   req_done;
  logic                 req_error;
  logic [7:0]           rd_data;
  logic                 busy;
  logic [7:0]           m_config;
  logic [6:0]           m_dev_addr;
  logic [7:0]           m_reg_addr;
  logic [7:0]           m_wr_data;
  logic [7:0]           m_ack;
  logic [7:0]           m_rd_data;

  int n_cmp = 0;
  int n_mis = 0;

  always #42 clk_12m = ~clk_12m;

  i2c_cmd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GAP_CYC (GAP_CYC)
`ifdef I2C_TIMEOUT_EN
    , .TIMEOUT_CYC (24'd100)
`endif
  ) dut (
    .clk_12m      (clk_12m),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_mode     (req_mode),
    .req_dev_addr (req_dev_addr),
    .req_reg_addr (req_reg_addr),
    .req_wr_data  (req_wr_data),
    .req_accept   (req_accept),
    .req_done     (req_done),
    .req_error    (req_error),
    .rd_data      (rd_data),
    .busy         (busy),
    .m_config     (m_config),
    .m_dev_addr   (m_dev_addr),
    .m_reg_addr   (m_reg_addr),
    .m_wr_data    (m_wr_data),
    .m_ack        (m_ack),
    .m_rd_data    (m_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [7:0] mode, input logic [6:0] dev,
                         input logic [7:0] rega, input logic [7:0] wdat);
    req_mode[8*idx +: 8]     = mode;
    req_dev_addr[7*idx +: 7] = dev;
    req_reg_addr[8*idx +: 8] = rega;
    req_wr_data[8*idx +: 8]  = wdat;
  endtask

  task automatic wait_accept(input string tag, input int limit);
    int n;
    n = 0;
    while (req_accept == '0 && n < limit) begin
      @(negedge clk_12m);
      n++;
    end
    if (n >= limit) chk({tag, " accept timeout"}, 32'(n), 32'(limit - 1));
  endtask

  // One legal transaction: accept, launch, core completes after dly cycles, then the gap.
  task automatic serve(input string tag, input logic [NUM_REQ-1:0] exp_gnt,
                       input logic [7:0] mode, input logic [6:0] dev, input logic [7:0] rega,
                       input logic [7:0] wdat, input int dly, input logic [7:0] ack_val,
                       input logic [7:0] rd_val, input logic exp_err, input logic [7:0] exp_rd,
                       input logic drop);
    int n;
    logic cfg_bad;
    wait_accept(tag, 100);
    chk({tag, " accept"}, 32'(req_accept), 32'(exp_gnt));
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    if (drop) req_valid = '0;
    @(negedge clk_12m);
    chk({tag, " accept pulse width"}, 32'(req_accept), 32'd0);
    chk({tag, " m_config"}, 32'(m_config), 32'(mode));
    chk({tag, " m_dev_addr"}, 32'(m_dev_addr), 32'(dev));
    chk({tag, " m_reg_addr"}, 32'(m_reg_addr), 32'(rega));
    chk({tag, " m_wr_data"}, 32'(m_wr_data), 32'(wdat));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    repeat (dly) @(negedge clk_12m);
    chk({tag, " m_config held"}, 32'(m_config), 32'(mode));
    m_ack     = ack_val;
    m_rd_data = rd_val;
    @(negedge clk_12m);
    chk({tag, " done +1"}, 32'(req_done), 32'd0);
    @(negedge clk_12m);
    chk({tag, " done +2"}, 32'(req_done), 32'd0);
    @(negedge clk_12m);
    chk({tag, " done +3"}, 32'(req_done), 32'(exp_gnt));
    chk({tag, " error"}, 32'(req_error), 32'(exp_err));
    chk({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd));
    chk({tag, " gap config"}, 32'(m_config), 32'h00);
    m_ack = 8'h00;
    n = 0;
    cfg_bad = 1'b0;
    while (busy && n < 100) begin
      @(negedge clk_12m);
      n++;
      if (m_config != 8'h00) cfg_bad = 1'b1;
      if (req_done != '0) cfg_bad = 1'b1;
    end
    chk({tag, " gap length"}, 32'(n), 32'(GAP_CYC));
    chk({tag, " gap quiet"}, 32'(cfg_bad), 32'd0);
  endtask

  initial begin
    #(84 * 50000);
    $display("FAIL watchdog: simulation did not finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_mode     = '0;
    req_dev_addr = '0;
    req_reg_addr = '0;
    req_wr_data  = '0;
    m_ack        = 8'h00;
    m_rd_data    = 8'h00;
    repeat (3) @(negedge clk_12m);
    chk("reset accept", 32'(req_accept), 32'd0);
    chk("reset done", 32'(req_done), 32'd0);
    chk("reset error", 32'(req_error), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset m_config", 32'(m_config), 32'h00);
    chk("reset rd_data", 32'(rd_data), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_12m);

    // Req0 single write, completion on m_ack[5] after 200 cycles.
    set_req(0, 8'h01, 7'h50, 8'h00, 8'h11);
    req_valid = 2'b01;
    serve("wr0", 2'b01, 8'h01, 7'h50, 8'h00, 8'h11, 200, 8'h20, 8'hEE, 1'b0, 8'h00, 1'b1);

    // Req1 single read returns 0x11.
    set_req(1, 8'h04, 7'h50, 8'h00, 8'h00);
    req_valid = 2'b10;
    serve("rd1", 2'b10, 8'h04, 7'h50, 8'h00, 8'h00, 20, 8'h20, 8'h11, 1'b0, 8'h11, 1'b1);

    // Both requesters held valid: grants must alternate starting at 0.
    set_req(0, 8'h01, 7'h50, 8'h01, 8'hA5);
    set_req(1, 8'h03, 7'h51, 8'h02, 8'h5A);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        serve($sformatf("alt%0d", i), 2'b01, 8'h01, 7'h50, 8'h01, 8'hA5, 10, 8'h04, 8'h00,
              1'b0, 8'h00, i == 5);
      else
        serve($sformatf("alt%0d", i), 2'b10, 8'h03, 7'h51, 8'h02, 8'h5A, 10, 8'h04, 8'h00,
              1'b0, 8'h00, i == 5);
    end

    // Completion with device-address NACK.
    set_req(0, 8'h01, 7'h52, 8'h10, 8'h33);
    req_valid = 2'b01;
    serve("nack", 2'b01, 8'h01, 7'h52, 8'h10, 8'h33, 20, 8'h06, 8'hEE, 1'b1, 8'h00, 1'b1);

    // Illegal mode: done+error the cycle after accept, core stays in Wait.
    set_req(0, 8'h07, 7'h50, 8'h00, 8'h00);
    req_valid = 2'b01;
    wait_accept("ill", 100);
    chk("ill accept", 32'(req_accept), 32'b01);
    req_valid = '0;
    @(negedge clk_12m);
    chk("ill done", 32'(req_done), 32'b01);
    chk("ill error", 32'(req_error), 32'd1);
    chk("ill m_config", 32'(m_config), 32'h00);
    chk("ill busy", 32'(busy), 32'd0);

    // A request raised and dropped while the gap runs must never be accepted.
    @(negedge clk_12m);
    set_req(1, 8'h01, 7'h50, 8'h00, 8'h00);
    req_valid = 2'b10;
    repeat (3) @(negedge clk_12m);
    req_valid = '0;
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_12m);
      if (req_accept != '0) n_acc++;
      if (m_config != 8'h00) n_acc++;
    end
    chk("dropped req ignored", 32'(n_acc), 32'd0);

    // Reset mid-BUSY clears outputs asynchronously and the pointer back to 0.
    set_req(0, 8'h01, 7'h50, 8'h00, 8'h11);
    req_valid = 2'b01;
    wait_accept("rst", 100);
    req_valid = '0;
    @(negedge clk_12m);
    chk("rst busy before", 32'(busy), 32'd1);
    #10;
    rst_n = 1'b0;
    #1;
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async m_config", 32'(m_config), 32'h00);
    chk("rst async m_dev_addr", 32'(m_dev_addr), 32'h00);
    @(negedge clk_12m);
    rst_n = 1'b1;
    @(negedge clk_12m);
    set_req(1, 8'h03, 7'h51, 8'h02, 8'h5A);
    req_valid = 2'b11;
    serve("post-rst", 2'b01, 8'h01, 7'h50, 8'h00, 8'h11, 10, 8'h04, 8'h00, 1'b0, 8'h00, 1'b1);

`ifdef I2C_TIMEOUT_EN
    begin
      int n_to;
      set_req(0, 8'h04, 7'h50, 8'h00, 8'h00);
      req_valid = 2'b01;
      wait_accept("to", 100);
      req_valid = '0;
      m_rd_data = 8'h77;
      @(negedge clk_12m);
      chk("to busy", 32'(busy), 32'd1);
      n_to = 0;
      while (req_done == '0 && n_to < 200) begin
        @(negedge clk_12m);
        n_to++;
      end
      chk("to cycles", 32'(n_to), 32'd100);
      chk("to error", 32'(req_error), 32'd1);
      chk("to rd_data", 32'(rd_data), 32'h00);
      repeat (GAP_CYC + 2) @(negedge clk_12m);
      chk("to idle", 32'(busy), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
